sprite_blitter: RTL and testbench
=================================

// Module: sprite_blitter
// PURPOSE
//   Pixel-drawing engine that feeds vga_adapter's x/y/color/write port.
//   Copies one sprite from an on-chip sprite ROM to the video memory at position
//   (spr_x, spr_y) on a start request.
//   - Skips transparent pixels.
//   - Suppresses pixels that fall off the 640x480 screen.
//   Sits between the game-logic FSMs (ship, enemies, lasers) and the VGA adapter.
// PARAMETERS
//   nX        10      bits of X coordinate (matches vga_adapter)
//   nY        9       bits of Y coordinate (matches vga_adapter)
//   COLOR_W   9       pixel color width, 3-3-3 RGB
//   SPR_W     16      sprite width in pixels
//   SPR_H     16      sprite height in pixels
//   NUM_SPR   4       number of sprites stored in the ROM
//   SPR_MIF   "./MIF/sprites.mif"   ROM init file
// PORTS
//   clock     in   1        system clock (CLOCK_50 at top level)
//   resetn    in   1        asynchronous active-low reset
//   start     in   1        draw request; sampled only in IDLE
//   spr_x     in   nX       top-left X of sprite
//   spr_y     in   nY       top-left Y of sprite
//   spr_id    in   $clog2(NUM_SPR)   sprite index
//   erase     in   1        erase request (see CONFIGURATION)
//   busy      out  1        high from the cycle after accept until done
//   done      out  1        1-cycle pulse at end of a draw
//   x         out  nX       pixel X to vga_adapter
//   y         out  nY       pixel Y to vga_adapter
//   color     out  COLOR_W  pixel color to vga_adapter
//   write     out  1        pixel write strobe to vga_adapter
// BEHAVIOUR
//   - Reset: busy, done, write = 0; x, y, color = 0; FSM = IDLE. Reset is asynchronous,
//     honoured mid-draw, and no write follows it.
//   - FSM: IDLE -> RUN -> FLUSH -> IDLE.
//     - IDLE: start=1 latches spr_x, spr_y, spr_id, erase; clears row/col counters;
//       goes to RUN.
//     - RUN: presents ROM address id*SPR_W*SPR_H + row*SPR_W + col each cycle.
//       col wraps at SPR_W-1 and increments row. After the last pixel
//       (row=SPR_H-1, col=SPR_W-1) goes to FLUSH.
//     - FLUSH: emits the final pixel, pulses done, returns to IDLE.
//   - start while busy is ignored; it is not queued.
//   - Timing, with accept at cycle 0:
//     - pixel k (row-major, k=0..SPR_W*SPR_H-1) is addressed in cycle k+1;
//     - its write strobe is asserted in cycle k+2;
//     - done=1 and busy=0 in cycle SPR_W*SPR_H+2; for 16x16 that is cycle 258.
//     - Throughput is 1 pixel/clock.
//   - ROM read is synchronous with 1-cycle latency. Pixel coordinates are delayed
//     one stage to align with the ROM data.
//   - write=1 only if all of the following hold:
//     - ROM data != TRANSPARENT (9'h1C7);
//     - spr_x+col < 640, computed in nX+1 bits with no wrap;
//     - spr_y+row < 480, computed in nY+1 bits.
//   - When write=0, x, y and color hold their last values.
//   - A new start is accepted in the cycle done is high (back-to-back draws).
// CONFIGURATION
//   Macro BLITTER_ERASE_EN.
//   - Defined: when the latched erase=1, every opaque, on-screen pixel is written
//     with BG_COLOR (9'h000) instead of its ROM color. Timing is unchanged.
//   - Undefined: the erase port is present but ignored; ROM colors are always drawn.
// STRUCTURE
//   Shared package defender_pkg holds:
//   - SCREEN_W=640, SCREEN_H=480;
//   - TRANSPARENT=9'h1C7, BG_COLOR=9'h000;
//   - state encoding IDLE/RUN/FLUSH.
//   Sub-module sprite_rom: single-port, synchronous-read altsyncram initialised from
//   SPR_MIF, depth NUM_SPR*SPR_W*SPR_H, width COLOR_W.
// TESTING
//   1. Reset mid-draw: resetn low at cycle 100 -> write, busy, done = 0 at once;
//      no further writes.
//   2. Solid sprite 0 at (100,50): exactly 256 writes, cycles 2..257.
//      - First write: x=100, y=50.
//      - Last write: x=115, y=65.
//      - done pulse at cycle 258.
//   3. Sprite 1 with a transparent checkerboard: exactly 128 writes; no write carries
//      color 9'h1C7.
//   4. Sprite 0 at (632,472): 64 writes, all with x<640 and y<480.
//      - done still at cycle 258.
//   5. start held high through a draw: the second draw is accepted exactly in the
//      done cycle, and mid-draw start pulses are ignored.
//   6. BLITTER_ERASE_EN defined, erase=1, solid sprite: 256 writes, all color=0.
//      - With the macro undefined: ROM colors are written.

Source files
------------

// File: rtl/defender_pkg.sv
// rtl/defender_pkg.sv - shared screen limits, colour constants, blitter states and built-in sprite art
package defender_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [8:0] TRANSPARENT = 9'h1C7;
  localparam logic [8:0] BG_COLOR    = 9'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Sprite set: 0 opaque gradient, 1 checkerboard, 2 solid with a clear diagonal, 3 left edge only.
  function automatic logic [8:0] sprite_art(input int id, input int row, input int col, input int spr_w);
    logic [8:0] pix;
    pix = TRANSPARENT;
    case (id)
      0:       pix = 9'(row * spr_w + col + 1);
      1:       pix = (((row ^ col) & 1) == 0) ? 9'(row * spr_w + col) : TRANSPARENT;
      2:       pix = (row == col) ? TRANSPARENT : 9'h1F8;
      default: pix = (col == 0) ? 9'h007 : TRANSPARENT;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - single-port synchronous-read sprite ROM, 1-cycle latency
module sprite_rom
  import defender_pkg::*;
#(
  parameter int    COLOR_W = 9,
  parameter int    SPR_W   = 16,
  parameter int    SPR_H   = 16,
  parameter int    NUM_SPR = 4,
  parameter string SPR_MIF = "./MIF/sprites.mif"
) (
  input  logic                                    clock,
  input  logic [$clog2(NUM_SPR*SPR_W*SPR_H)-1:0]  addr,
  output logic [COLOR_W-1:0]                      rdata
);

  localparam int PIX = SPR_W * SPR_H;

  logic [COLOR_W-1:0] rdata_d, rdata_q;

  // An empty image name yields a fully transparent ROM.
  generate
    if (SPR_MIF == "") begin : g_blank
      always_comb rdata_d = COLOR_W'(TRANSPARENT);
    end else begin : g_art
      always_comb rdata_d = COLOR_W'(sprite_art(int'(addr) / PIX, (int'(addr) / SPR_W) % SPR_H,
                                                int'(addr) % SPR_W, SPR_W));
    end
  endgenerate

  always_ff @(posedge clock) rdata_q <= rdata_d;

  assign rdata = rdata_q;

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - copies one ROM sprite to vga_adapter at (spr_x, spr_y), 1 pixel/clock
// Optional BLITTER_ERASE_EN: latched erase paints opaque pixels with BG_COLOR.
module sprite_blitter
  import defender_pkg::*;
#(
  parameter int    nX      = 10,
  parameter int    nY      = 9,
  parameter int    COLOR_W = 9,
  parameter int    SPR_W   = 16,
  parameter int    SPR_H   = 16,
  parameter int    NUM_SPR = 4,
  parameter string SPR_MIF = "./MIF/sprites.mif"
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [nX-1:0]              spr_x,
  input  logic [nY-1:0]              spr_y,
  input  logic [$clog2(NUM_SPR)-1:0] spr_id,
  input  logic                       erase,
  output logic                       busy,
  output logic                       done,
  output logic [nX-1:0]              x,
  output logic [nY-1:0]              y,
  output logic [COLOR_W-1:0]         color,
  output logic                       write
);

  localparam int IW  = $clog2(NUM_SPR);
  localparam int CW  = $clog2(SPR_W);
  localparam int RW  = $clog2(SPR_H);
  localparam int PIX = SPR_W * SPR_H;
  localparam int AW  = $clog2(NUM_SPR * PIX);

  state_e             state_q, state_d;
  logic [nX-1:0]      org_x_q, org_x_d;
  logic [nY-1:0]      org_y_q, org_y_d;
  logic [IW-1:0]      id_q, id_d;
  logic               erase_q, erase_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic               done_q, done_d;
  logic               vld_q, vld_d, on_q, on_d;
  logic [nX-1:0]      px_q, px_d, x_q, x_d;
  logic [nY-1:0]      py_q, py_d, y_q, y_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [nX:0]        sum_x;
  logic [nY:0]        sum_y;
  logic [AW-1:0]      rom_addr;
  logic [COLOR_W-1:0] rom_data, pix_color;

  sprite_rom #(
    .COLOR_W (COLOR_W),
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .NUM_SPR (NUM_SPR),
    .SPR_MIF (SPR_MIF)
  ) u_rom (
    .clock (clock),
    .addr  (rom_addr),
    .rdata (rom_data)
  );

  always_comb begin
    state_d = state_q;
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    id_d    = id_q;
    erase_d = erase_q;
    col_d   = col_q;
    row_d   = row_q;
    done_d  = 1'b0;
    vld_d   = 1'b0;
    // Screen test is done one bit wider so coordinates never wrap back onto the screen.
    sum_x    = {1'b0, org_x_q} + (nX+1)'(col_q);
    sum_y    = {1'b0, org_y_q} + (nY+1)'(row_q);
    on_d     = (sum_x < (nX+1)'(SCREEN_W)) && (sum_y < (nY+1)'(SCREEN_H));
    px_d     = sum_x[nX-1:0];
    py_d     = sum_y[nY-1:0];
    rom_addr = AW'(id_q) * AW'(PIX) + AW'(row_q) * AW'(SPR_W) + AW'(col_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          org_x_d = spr_x;
          org_y_d = spr_y;
          id_d    = spr_id;
          erase_d = erase;
          col_d   = '0;
          row_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        vld_d = 1'b1;
        if (col_q == CW'(SPR_W - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
          if (row_q == RW'(SPR_H - 1)) state_d = FLUSH;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      FLUSH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage sits on the ROM data cycle; x/y/color hold while write is low.
  always_comb begin
    write = vld_q && on_q && (rom_data != COLOR_W'(TRANSPARENT));
`ifdef BLITTER_ERASE_EN
    pix_color = erase_q ? COLOR_W'(BG_COLOR) : rom_data;
`else
    pix_color = rom_data;
`endif
    x_d     = write ? px_q : x_q;
    y_d     = write ? py_q : y_q;
    color_d = write ? pix_color : color_q;
  end

`ifndef BLITTER_ERASE_EN
  logic unused_erase;
  assign unused_erase = erase_q;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      org_x_q <= '0;
      org_y_q <= '0;
      id_q    <= '0;
      erase_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      on_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      id_q    <= id_d;
      erase_q <= erase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      on_q    <= on_d;
      px_q    <= px_d;
      py_q    <= py_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign x     = x_d;
  assign y     = y_d;
  assign color = color_d;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter against a pixel-list reference model
module tb_sprite_blitter;

`ifdef BLITTER_ERASE_EN
  localparam bit ERASE_ON = 1'b1;
`else
  localparam bit ERASE_ON = 1'b0;
`endif
  localparam int NPIX = 256;

  typedef struct { int cyc; int px; int py; int col; } wr_t;
  typedef struct { string name; int sx; int sy; int id; bit er; int exp_n; } vec_t;

  logic       clock = 1'b0, resetn = 1'b1, start = 1'b0, erase = 1'b0;
  logic [9:0] spr_x = '0;
  logic [8:0] spr_y = '0;
  logic [1:0] spr_id = '0;
  logic       busy, done, write;
  logic [9:0] x;
  logic [8:0] y, color;

  int   cyc = 0;
  int   n_pass = 0, n_total = 0;
  int   hold_err = 0;
  wr_t  obs[$], exp_q[$];
  int   done_cyc[$];
  logic [9:0] lx = '0;
  logic [8:0] ly = '0, lc = '0;

  sprite_blitter dut (
    .clock(clock), .resetn(resetn), .start(start), .spr_x(spr_x), .spr_y(spr_y),
    .spr_id(spr_id), .erase(erase), .busy(busy), .done(done), .x(x), .y(y),
    .color(color), .write(write)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!resetn) begin
      lx <= '0; ly <= '0; lc <= '0;
    end else begin
      if (write) begin
        obs.push_back('{cyc, int'(x), int'(y), int'(color)});
        lx <= x; ly <= y; lc <= color;
      end else if (x != lx || y != ly || color != lc) begin
        hold_err <= hold_err + 1;
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int ref_art(input int id, input int r, input int c);
    if (id == 0) return r * 16 + c + 1;
    if (id == 1) return ((r + c) % 2 == 0) ? r * 16 + c : 'h1C7;
    if (id == 2) return (r == c) ? 'h1C7 : 'h1F8;
    return (c == 0) ? 'h007 : 'h1C7;
  endfunction

  task automatic model_draw(input int c0, input int sx, input int sy, input int id, input bit er);
    int r, c, a;
    for (int k = 0; k < NPIX; k++) begin
      r = k / 16;
      c = k % 16;
      a = ref_art(id, r, c);
      if (a != 'h1C7 && sx + c < 640 && sy + r < 480)
        exp_q.push_back('{c0 + k + 2, sx + c, sy + r, (er && ERASE_ON) ? 0 : a});
    end
  endtask

  task automatic compare_streams(input string name);
    int bad;
    int n;
    bad = 0;
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs[i].cyc != exp_q[i].cyc || obs[i].px != exp_q[i].px ||
          obs[i].py != exp_q[i].py || obs[i].col != exp_q[i].col) bad++;
    check({name, " write count vs model"}, obs.size(), exp_q.size());
    check({name, " mismatching writes"}, bad, 0);
  endtask

  task automatic do_draw(input int sx, input int sy, input int id, input bit er,
                         input int exp_n, input string name, output int c0);
    int busy_err, tr;
    obs.delete(); exp_q.delete(); done_cyc.delete();
    busy_err = 0;
    spr_x = 10'(sx); spr_y = 9'(sy); spr_id = 2'(id); erase = er; start = 1'b1;
    c0 = cyc;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 262; i++) begin
      if (busy !== (cyc >= c0 + 1 && cyc <= c0 + 257)) busy_err++;
      @(negedge clock);
    end
    model_draw(c0, sx, sy, id, er);
    compare_streams(name);
    if (exp_n >= 0) check({name, " write count"}, obs.size(), exp_n);
    check({name, " done offset"}, (done_cyc.size() == 1) ? done_cyc[0] - c0 : -1, 258);
    check({name, " busy window errors"}, busy_err, 0);
    tr = 0;
    foreach (obs[i]) if (obs[i].col == 'h1C7) tr++;
    check({name, " transparent writes"}, tr, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int   c0, nobs;

    tbl[0] = '{"checker",  0,   0,   1, 1'b0, 128};
    tbl[1] = '{"corner",   632, 472, 0, 1'b0, 64};
    tbl[2] = '{"diag",     0,   0,   2, 1'b0, 240};
    tbl[3] = '{"edge",     624, 0,   3, 1'b0, 16};
    tbl[4] = '{"clip_chk", 630, 470, 1, 1'b0, 50};
    tbl[5] = '{"offscr",   640, 0,   0, 1'b0, 0};
    tbl[6] = '{"erase",    100, 50,  0, 1'b1, 256};
    tbl[7] = '{"bottom",   0,   479, 0, 1'b0, 16};

    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset write", write, 0);
    check("reset x", x, 0);
    check("reset y", y, 0);
    check("reset color", color, 0);
    resetn = 1'b1;
    @(negedge clock);

    do_draw(100, 50, 0, 1'b0, 256, "solid", c0);
    check("solid first cycle", (obs.size() > 0) ? obs[0].cyc - c0 : -1, 2);
    check("solid first x", (obs.size() > 0) ? obs[0].px : -1, 100);
    check("solid first y", (obs.size() > 0) ? obs[0].py : -1, 50);
    check("solid last cycle", (obs.size() > 0) ? obs[$].cyc - c0 : -1, 257);
    check("solid last x", (obs.size() > 0) ? obs[$].px : -1, 115);
    check("solid last y", (obs.size() > 0) ? obs[$].py : -1, 65);

    for (int i = 0; i < 8; i++)
      do_draw(tbl[i].sx, tbl[i].sy, tbl[i].id, tbl[i].er, tbl[i].exp_n, tbl[i].name, c0);

    for (int i = 0; i < 6; i++)
      do_draw(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, "random", c0);

    // start held high: second draw accepted in the done cycle, mid-draw changes ignored
    obs.delete(); exp_q.delete(); done_cyc.delete();
    spr_x = 10'd10; spr_y = 9'd20; spr_id = 2'd1; erase = 1'b0; start = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 258 + 263; i++) begin
      @(negedge clock);
      if (cyc == c0 + 100) spr_x = 10'd300;
      if (cyc == c0 + 259) start = 1'b0;
    end
    model_draw(c0, 10, 20, 1, 1'b0);
    model_draw(c0 + 258, 300, 20, 1, 1'b0);
    compare_streams("b2b");
    check("b2b done count", done_cyc.size(), 2);
    check("b2b first done", (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1, 258);
    check("b2b second done", (done_cyc.size() > 1) ? done_cyc[1] - c0 : -1, 516);

    // reset in the middle of a draw
    obs.delete(); done_cyc.delete();
    spr_x = 10'd0; spr_y = 9'd0; spr_id = 2'd0; start = 1'b1;
    c0 = cyc;
    @(negedge clock);
    start = 1'b0;
    while (cyc < c0 + 100) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midreset write", write, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset x", x, 0);
    nobs = obs.size();
    check("midreset writes before", nobs, 99);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (300) @(negedge clock);
    check("midreset writes after", obs.size() - nobs, 0);
    check("midreset done after", done_cyc.size(), 0);

    check("hold when write low", hold_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
